fsm_mini_sched: RTL and testbench

Round-robin scheduler that shares one byte-processing engine (the `fsm_mini` datapath) between `NREQ` requesters. It does three things:
- accepts one byte job at a time;
- sequences the engine's start/data handshake and waits for `done`;
- recovers the engine with a fixed byte stream when it stalls (error/wait paths), then returns a tagged response.

It sits between the request fabric and a single engine instance.

---
 rtl/fsm_mini_pkg.sv | 17 +
 rtl/fsm_mini_sched_rr_arbiter.sv | 37 +++
 rtl/fsm_mini_sched.sv | 124 ++++++++++++
 tb/tb_fsm_mini_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_mini_pkg.sv
// Shared types and constants for the byte-engine scheduler and its engine.
// The recovery defaults match the byte stream the engine uses to leave its error/wait states.
package fsm_mini_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_RECOVER,
        S_RESP
    } sched_state_t;

    localparam logic [7:0] SCHED_ERR_BYTE   = 8'hEE;
    localparam logic [7:0] DEF_RECOVER_BYTE = 8'h07;
    localparam int         DEF_TIMEOUT      = 64;

endpackage

// File: rtl/fsm_mini_sched_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, searching upward with wrap.
// Purely combinational; grants nothing while en is low.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [2*NREQ-1:0] rot;
    logic              found;
    int                pos;

    // Doubling the vector lets a plain shift express the wrap-around search.
    assign rot = {req, req} >> ptr;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (en && !found && rot[k]) begin
                found = 1'b1;
                pos   = int'(ptr) + k;
                if (pos >= NREQ) pos = pos - NREQ;
                gnt_idx = IDW'(pos);
                gnt     = NREQ'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/fsm_mini_sched.sv
// Round-robin scheduler sharing one byte engine: grant, start, run with timeout, recover, respond.
// Grant-to-response at least 3 cycles; response is held until resp_ready, no new grant meanwhile.
module fsm_mini_sched
    import fsm_mini_pkg::*;
#(
    parameter int         NREQ           = 4,
    parameter int         IDW            = $clog2(NREQ),
    parameter int         TIMEOUT        = DEF_TIMEOUT,
    parameter int         RECOVER_CYCLES = 2,
    parameter logic [7:0] RECOVER_BYTE   = DEF_RECOVER_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [7:0]        resp_data,
    output logic              resp_err,
    output logic              eng_start,
    output logic [7:0]        eng_data,
    input  logic [7:0]        eng_data_out,
    input  logic              eng_done,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    sched_state_t    state, state_nxt;
    logic [IDW-1:0]  rr_ptr, job_id, gnt_idx, ptr_nxt;
    logic [NREQ-1:0] gnt;
    logic [7:0]      job_byte, job_byte_nxt, eng_data_nxt;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   rec_cnt;
    logic            grant_en, granted, timer_expired, rec_last;

    // Gating with rst_n keeps req_ready low while reset is held.
    assign grant_en = (state == S_IDLE) && rst_n;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready     = gnt;
    assign granted       = |gnt;
    assign timer_expired = (timer == TW'(TIMEOUT - 1));
    assign rec_last      = (rec_cnt == RW'(RECOVER_CYCLES - 1));
    assign ptr_nxt       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign job_byte_nxt  = granted ? req_data[{gnt_idx, 3'b000} +: 8] : job_byte;

    always_comb begin
        state_nxt    = state;
        eng_data_nxt = 8'h00;
        case (state)
            S_IDLE:    if (granted) state_nxt = S_START;
            S_START:   state_nxt = S_RUN;
            S_RUN: begin
                if (eng_done)           state_nxt = S_RESP;
                else if (timer_expired) state_nxt = S_RECOVER;
            end
            S_RECOVER: if (rec_last) state_nxt = S_RESP;
            S_RESP:    if (resp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        case (state_nxt)
            S_START, S_RUN: eng_data_nxt = job_byte_nxt;
            S_RECOVER:      eng_data_nxt = RECOVER_BYTE;
            default:        eng_data_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            job_id     <= '0;
            job_byte   <= 8'h00;
            timer      <= '0;
            rec_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= 8'h00;
            resp_err   <= 1'b0;
            eng_start  <= 1'b0;
            eng_data   <= 8'h00;
            busy       <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            state      <= state_nxt;
            job_byte   <= job_byte_nxt;
            eng_start  <= (state_nxt == S_START);
            eng_data   <= eng_data_nxt;
            busy       <= (state_nxt != S_IDLE);
            resp_valid <= (state_nxt == S_RESP);
            rec_cnt    <= (state == S_RECOVER) ? rec_cnt + 1'b1 : '0;
            if (granted) begin
                job_id <= gnt_idx;
                rr_ptr <= ptr_nxt;
            end
            if (state == S_START)    timer <= '0;
            else if (state == S_RUN) timer <= timer + 1'b1;
            if (state == S_RUN && eng_done) begin
                resp_id   <= job_id;
                resp_data <= eng_data_out;
                resp_err  <= 1'b0;
            end else if (state == S_RUN && timer_expired) begin
                resp_id   <= job_id;
                resp_data <= SCHED_ERR_BYTE;
                resp_err  <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_mini_sched.sv
// Bench for fsm_mini_sched: scenario tasks plus randomized jobs against a transaction-level model.
module tb_fsm_mini_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 64;
    localparam int RC   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IDW-1:0]    resp_id;
    logic [7:0]        resp_data;
    logic              resp_err;
    logic              eng_start;
    logic [7:0]        eng_data;
    logic [7:0]        eng_data_out = 8'h00;
    logic              eng_done = 1'b0;
    logic              busy;
    logic [7:0]        err_count;

    fsm_mini_sched dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .eng_start(eng_start), .eng_data(eng_data), .eng_data_out(eng_data_out),
        .eng_done(eng_done), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model state: round-robin pointer and saturating error count.
    int m_ptr = 0;
    int m_err = 0;

    // Observations of the last job, t = cycles since the grant cycle.
    logic [7:0]      tr_data [0:255];
    logic            tr_start[0:255];
    logic [NREQ-1:0] o_gnt;
    int              o_gcyc, o_start_t, o_resp_t;
    logic [IDW-1:0]  o_id;
    logic [7:0]      o_data;
    logic            o_err, o_stable, o_rdy_in_resp, o_timeout;

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    // Drives one job through the DUT with a simple engine model; records what it saw.
    // done_at: engine pulses done on that RUN-relative cycle after start (0 = never).
    task automatic do_job(input logic [NREQ-1:0] valid, input logic [31:0] data, input int done_at,
                          input logic [7:0] done_byte, input int ready_wait, input bit keep_valid,
                          input bit spur);
        int t;
        int w;
        o_timeout = 0; o_start_t = -1; o_resp_t = -1; o_stable = 1; o_rdy_in_resp = 0; o_gnt = '0;
        req_valid = valid; req_data = data; resp_ready = 0;
        #1;
        w = 0;
        while (req_ready == '0 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        if (req_ready == '0) begin
            o_timeout = 1; req_valid = '0; return;
        end
        o_gnt = req_ready; o_gcyc = cyc; t = 0;
        for (int i = 0; i < 256; i++) begin tr_data[i] = 8'h00; tr_start[i] = 1'b0; end
        tr_data[0] = eng_data; tr_start[0] = eng_start;
        while (o_resp_t < 0 && t < 250) begin
            @(negedge clk);
            t++;
            if (!keep_valid) req_valid = '0;
            eng_done = (spur && t == 1) || (o_start_t >= 0 && done_at > 0 && t == o_start_t + done_at);
            eng_data_out = eng_done ? done_byte : 8'h5A;
            #1;
            tr_data[t] = eng_data; tr_start[t] = eng_start;
            if (eng_start && o_start_t < 0) o_start_t = t;
            if (resp_valid) o_resp_t = t;
        end
        eng_done = 0;
        if (o_resp_t < 0) begin
            o_timeout = 1; return;
        end
        o_id = resp_id; o_data = resp_data; o_err = resp_err;
        for (int i = 0; ; i++) begin
            if (!resp_valid || resp_id !== o_id || resp_data !== o_data || resp_err !== o_err) o_stable = 0;
            if (req_ready !== '0) o_rdy_in_resp = 1;
            if (i == ready_wait) begin
                resp_ready = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk); #1;
        end
        resp_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; req_valid = '1; req_data = '0; resp_ready = 0; eng_done = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if ({busy, resp_valid, eng_start, resp_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b expected 0000", {busy, resp_valid, eng_start, resp_err});
        end
        checks++;
        if ({resp_id, resp_data, eng_data, err_count} !== '0) begin
            failures++; $display("FAIL reset_values: id=%0d data=%h eng=%h errs=%0d expected all 0", resp_id, resp_data, eng_data, err_count);
        end
        @(negedge clk);
        rst_n = 1; req_valid = '0; m_ptr = 0; m_err = 0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_single;
        logic bad;
        do_job(4'b0001, 32'h0000_0035, 3, 8'h36, 0, 0, 0);
        checks++;
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL single_done: got timeout expected response"); end
        checks++;
        if (o_gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b expected 0001", o_gnt); end
        checks++;
        if (o_start_t !== 1 || tr_start[2] !== 1'b0) begin
            failures++; $display("FAIL single_start: got t=%0d/next=%b expected t=1 one-cycle", o_start_t, tr_start[2]);
        end
        bad = 0;
        for (int t = 1; t <= 4; t++) if (tr_data[t] !== 8'h35) bad = 1;
        checks++;
        if (bad) begin failures++; $display("FAIL single_eng_data: got %h..%h expected 35", tr_data[1], tr_data[4]); end
        checks++;
        if (o_resp_t !== 5) begin failures++; $display("FAIL single_latency: got %0d expected 5", o_resp_t); end
        checks++;
        if ({o_id, o_data, o_err} !== {2'd0, 8'h36, 1'b0}) begin
            failures++; $display("FAIL single_resp: got id=%0d data=%h err=%b expected 0/36/0", o_id, o_data, o_err);
        end
        m_ptr = 1;
    endtask

    task automatic test_rr_order;
        int g;
        int prev;
        logic [31:0] d;
        d = 32'h4433_2211;
        prev = -1;
        for (int j = 0; j < 5; j++) begin
            g = exp_grant(4'hF, m_ptr);
            do_job(4'hF, d, 1, d[8*g +: 8] ^ 8'hFF, 0, 1, 0);
            checks++;
            if (o_gnt !== onehot(g) || o_id !== IDW'(g)) begin
                failures++; $display("FAIL rr_grant%0d: got %b id=%0d expected id %0d", j, o_gnt, o_id, g);
            end
            checks++;
            if (tr_data[2] !== d[8*g +: 8] || o_data !== (d[8*g +: 8] ^ 8'hFF)) begin
                failures++; $display("FAIL rr_data%0d: got eng=%h resp=%h expected %h", j, tr_data[2], o_data, d[8*g +: 8]);
            end
            checks++;
            if (o_rdy_in_resp !== 1'b0) begin failures++; $display("FAIL rr_gnt_in_resp%0d: got grant expected none", j); end
            if (prev >= 0) begin
                checks++;
                if (o_gcyc - prev !== 4) begin failures++; $display("FAIL rr_gap%0d: got %0d expected 4", j, o_gcyc - prev); end
            end
            prev = o_gcyc;
            m_ptr = (g + 1) % NREQ;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout;
        logic bad;
        int g;
        g = exp_grant(4'b0100, m_ptr);
        do_job(4'b0100, 32'h00A5_0000, 0, 8'h00, 0, 0, 0);
        bad = 0;
        for (int t = 1; t <= 1 + TO; t++) if (tr_data[t] !== 8'hA5) bad = 1;
        checks++;
        if (bad) begin failures++; $display("FAIL to_run_data: got mismatch expected A5 through t=%0d", 1 + TO); end
        checks++;
        if (tr_data[2 + TO] !== 8'h07 || tr_data[3 + TO] !== 8'h07 || tr_data[4 + TO] !== 8'h00) begin
            failures++; $display("FAIL to_recover_data: got %h %h %h expected 07 07 00", tr_data[2 + TO], tr_data[3 + TO], tr_data[4 + TO]);
        end
        checks++;
        if (o_resp_t !== 2 + TO + RC) begin failures++; $display("FAIL to_latency: got %0d expected %0d", o_resp_t, 2 + TO + RC); end
        checks++;
        if ({o_id, o_data, o_err} !== {IDW'(g), 8'hEE, 1'b1}) begin
            failures++; $display("FAIL to_resp: got id=%0d data=%h err=%b expected %0d/EE/1", o_id, o_data, o_err, g);
        end
        m_ptr = (g + 1) % NREQ; m_err = 1;
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("FAIL to_err_count: got %0d expected 1", err_count); end
    endtask

    task automatic test_done_at_expiry;
        int g;
        g = exp_grant(4'b1000, m_ptr);
        do_job(4'b1000, 32'h3C00_0000, TO, 8'h9D, 0, 0, 1);
        checks++;
        if (o_resp_t !== 2 + TO) begin failures++; $display("FAIL exp_latency: got %0d expected %0d", o_resp_t, 2 + TO); end
        checks++;
        if ({o_data, o_err} !== {8'h9D, 1'b0}) begin
            failures++; $display("FAIL exp_resp: got data=%h err=%b expected 9D/0", o_data, o_err);
        end
        checks++;
        if (err_count !== 8'(m_err)) begin failures++; $display("FAIL exp_err_count: got %0d expected %0d", err_count, m_err); end
        m_ptr = (g + 1) % NREQ;
    endtask

    task automatic test_backpressure;
        int g;
        g = exp_grant(4'hF, m_ptr);
        do_job(4'hF, 32'h1234_5678, 2, 8'h61, 10, 1, 0);
        m_ptr = (g + 1) % NREQ;
        checks++;
        if (o_resp_t !== 4) begin failures++; $display("FAIL bp_latency: got %0d expected 4", o_resp_t); end
        checks++;
        if (o_stable !== 1'b1) begin failures++; $display("FAIL bp_stable: got unstable response expected held"); end
        checks++;
        if (o_rdy_in_resp !== 1'b0) begin failures++; $display("FAIL bp_req_ready: got grant during response expected none"); end
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== onehot(exp_grant(4'hF, m_ptr))) begin
            failures++; $display("FAIL bp_back_idle: got valid=%b ready=%b expected 0/%b", resp_valid, req_ready, onehot(exp_grant(4'hF, m_ptr)));
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int g, da, rw, exp_t;
        bit kv, sp, tout;
        logic [NREQ-1:0] v;
        logic [31:0] d;
        logic [7:0] db, eb;
        for (int j = 0; j < 30; j++) begin
            v = NREQ'($urandom_range(1, 15));
            d = $urandom;
            db = 8'($urandom);
            case ($urandom_range(0, 9))
                7:       da = TO;
                8:       da = TO + 1;
                9:       da = 0;
                default: da = $urandom_range(1, 6);
            endcase
            rw = $urandom_range(0, 3);
            kv = 1'($urandom);
            sp = 1'($urandom);
            g = exp_grant(v, m_ptr);
            eb = d[8*g +: 8];
            tout = (da == 0 || da > TO);
            exp_t = tout ? 2 + TO + RC : 2 + da;
            do_job(v, d, da, db, rw, kv, sp);
            m_ptr = (g + 1) % NREQ;
            if (tout && m_err < 255) m_err++;
            checks++;
            if (o_gnt !== onehot(g) || o_id !== IDW'(g) || tr_data[2] !== eb) begin
                failures++; $display("FAIL rnd_grant%0d: got %b id=%0d byte=%h expected id %0d byte %h", j, o_gnt, o_id, tr_data[2], g, eb);
            end
            checks++;
            if (o_resp_t !== exp_t || o_err !== tout || o_data !== (tout ? 8'hEE : db)) begin
                failures++; $display("FAIL rnd_resp%0d: got t=%0d err=%b data=%h expected t=%0d err=%b data=%h",
                                     j, o_resp_t, o_err, o_data, exp_t, tout, tout ? 8'hEE : db);
            end
            checks++;
            if (err_count !== 8'(m_err) || o_stable !== 1'b1) begin
                failures++; $display("FAIL rnd_errs%0d: got %0d stable=%b expected %0d stable", j, err_count, o_stable, m_err);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_job;
        do_job(4'b0100, 32'h00AB_0000, 1, 8'h11, 0, 0, 0);
        checks++;
        if (o_gnt !== 4'b0100) begin failures++; $display("FAIL mid_pre_gnt: got %b expected 0100", o_gnt); end
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || eng_data !== 8'hAB) begin
            failures++; $display("FAIL mid_running: got busy=%b eng=%h expected 1/AB", busy, eng_data);
        end
        rst_n = 0; req_valid = '1;
        #1;
        checks++;
        if ({req_ready, busy, resp_valid, eng_start, resp_err, resp_id, resp_data, eng_data, err_count} !== '0) begin
            failures++; $display("FAIL mid_reset_outputs: got rdy=%b busy=%b eng=%h errs=%0d expected all 0", req_ready, busy, eng_data, err_count);
        end
        m_ptr = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1; req_valid = '0;
        @(negedge clk);
        do_job(4'b1100, 32'h7700_0000, 2, 8'h22, 0, 0, 0);
        checks++;
        if (o_gnt !== 4'b0100 || o_id !== 2'd2) begin
            failures++; $display("FAIL mid_first_gnt: got %b id=%0d expected 0100 id 2", o_gnt, o_id);
        end
        checks++;
        if (o_resp_t !== 4 || {o_data, o_err} !== {8'h22, 1'b0}) begin
            failures++; $display("FAIL mid_fresh_resp: got t=%0d data=%h err=%b expected 4/22/0", o_resp_t, o_data, o_err);
        end
        m_ptr = 3;
    endtask

    task automatic test_err_saturate;
        int g;
        int n;
        n = 0;
        while (m_err < 255 && n < 300) begin
            g = exp_grant(4'b0010, m_ptr);
            do_job(4'b0010, 32'h0000_4200, 0, 8'h00, 0, 0, 0);
            m_ptr = (g + 1) % NREQ;
            m_err++;
            n++;
        end
        checks++;
        if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_reach: got %0d expected 255", err_count); end
        do_job(4'b0010, 32'h0000_4200, 0, 8'h00, 0, 0, 0);
        checks++;
        if (err_count !== 8'hFF || o_err !== 1'b1) begin
            failures++; $display("FAIL sat_hold: got %0d err=%b expected 255/1", err_count, o_err);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_rr_order;
        test_timeout;
        test_done_at_expiry;
        test_backpressure;
        test_random;
        test_reset_mid_job;
        test_err_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
